// File: rtl/fft_pkg.sv
// fft_pkg: shared complex sample type, defaults and bin-index helpers for the FFT datapath.
package fft_pkg;
   localparam int POINT_FFT_POW2_DEF = 4;
   localparam int FRAC_BITS_DEF = 15;
   localparam int RE = 0;
   localparam int IM = 1;
   typedef logic signed [1:0][FRAC_BITS_DEF:0] cplx_t;
   function automatic int unsigned bitrev(input int unsigned idx, input int unsigned width);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < width; i++) r = (r << 1) | ((idx >> i) & 1);
      return r;
   endfunction
endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// fft_bitrev_reorder_if: input/output sample streams of the bit-reversal reorder buffer.
interface fft_bitrev_reorder_if #(
   parameter int POINT_FFT_POW2 = 4,
   parameter int FRAC_BITS = 15
);
   logic in_valid_i;
   logic in_ready_o;
   logic signed [1:0][FRAC_BITS:0] in_data_i;
   logic in_last_i;
   logic out_valid_o;
   logic out_ready_i;
   logic signed [1:0][FRAC_BITS:0] out_data_o;
   logic [POINT_FFT_POW2-1:0] out_index_o;
   logic out_last_o;
   logic frame_err_o;
   modport master (
      output in_valid_i, in_data_i, in_last_i, out_ready_i,
      input in_ready_o, out_valid_o, out_data_o, out_index_o, out_last_o, frame_err_o
   );
   modport slave (
      input in_valid_i, in_data_i, in_last_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_index_o, out_last_o, frame_err_o
   );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed FFT output into natural bin order.
module fft_bitrev_reorder
   import fft_pkg::*;
#(
   parameter int POINT_FFT_POW2 = POINT_FFT_POW2_DEF,
   parameter int FRAC_BITS = FRAC_BITS_DEF,
   localparam int POINT_FFT = 1 << POINT_FFT_POW2
) (
   input logic clk_i,
   input logic rst_ni,
   fft_bitrev_reorder_if.slave s
);
   typedef logic [POINT_FFT_POW2-1:0] idx_t;
   typedef logic signed [1:0][FRAC_BITS:0] smp_t;
   smp_t bank [2][POINT_FFT];
   logic [1:0] full;
   logic wr_bank, rd_bank, err;
   idx_t wr_cnt, rd_cnt;
   logic in_acc, out_acc, wr_end, rd_end;
   always_comb begin
      wr_end = wr_cnt == idx_t'(POINT_FFT - 1);
      rd_end = rd_cnt == idx_t'(POINT_FFT - 1);
      in_acc = s.in_valid_i && !full[wr_bank];
      out_acc = s.out_ready_i && full[rd_bank];
   end
   // scatter on write so the read side walks the bank linearly
   always_ff @(posedge clk_i)
      if (in_acc) bank[wr_bank][idx_t'(bitrev(32'(wr_cnt), POINT_FFT_POW2))] <= s.in_data_i;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         full <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_cnt <= '0;
         rd_cnt <= '0;
         err <= 1'b0;
      end else begin
         if (in_acc) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (s.in_last_i != wr_end) err <= 1'b1;
            if (wr_end) begin
               full[wr_bank] <= 1'b1;
               wr_bank <= !wr_bank;
            end
         end
         // a completing read always targets the other bank, so both flag updates stand
         if (out_acc) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_end) begin
               full[rd_bank] <= 1'b0;
               rd_bank <= !rd_bank;
            end
         end
      end
   always_comb begin
      s.in_ready_o = !full[wr_bank];
      s.out_valid_o = full[rd_bank];
      s.out_data_o = full[rd_bank] ? bank[rd_bank][rd_cnt] : '0;
      s.out_index_o = rd_cnt;
      s.out_last_o = full[rd_bank] && rd_end;
      s.frame_err_o = err;
   end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: directed and random streams checked against a frame-queue reference model.
module tb_fft_bitrev_reorder;
   typedef logic [31:0] frame_t [16];
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_cmp = 0;
   int n_err = 0;
   int n_in = 0;
   int n_out = 0;
   int wc = 0;
   int rc = 0;
   int cyc = 0;
   logic m_err = 1'b0;
   frame_t pf;
   frame_t q[$];
   logic [15:0] seen_re;
   int exp_re [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   fft_bitrev_reorder_if #(.POINT_FFT_POW2(4), .FRAC_BITS(15)) bus ();
   fft_bitrev_reorder #(.POINT_FFT_POW2(4), .FRAC_BITS(15)) dut (.clk_i(clk), .rst_ni(rst_n), .s(bus));

   always #5 clk = !clk;

   function automatic int rev4(input int k);
      int r = 0;
      for (int i = 0; i < 4; i++) r = r * 2 + ((k >> i) % 2);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic v, input logic [15:0] re, input logic [15:0] im, input logic last, input logic rdy);
      logic m_rdy, m_val, ia, oa;
      bus.in_valid_i = v;
      bus.in_data_i = {im, re};
      bus.in_last_i = last;
      bus.out_ready_i = rdy;
      #1;
      m_rdy = q.size() < 2;
      m_val = q.size() > 0;
      chk("in_ready", 32'(bus.in_ready_o), 32'(m_rdy));
      chk("out_valid", 32'(bus.out_valid_o), 32'(m_val));
      chk("out_data", bus.out_data_o, m_val ? q[0][rc] : 32'h0);
      chk("out_index", 32'(bus.out_index_o), 32'(rc));
      chk("out_last", 32'(bus.out_last_o), 32'(m_val && rc == 15));
      chk("frame_err", 32'(bus.frame_err_o), 32'(m_err));
      seen_re = bus.out_data_o[0];
      ia = v && m_rdy;
      oa = rdy && m_val;
      @(posedge clk);
      #1;
      cyc++;
      if (oa) begin
         n_out++;
         if (rc == 15) begin
            void'(q.pop_front());
            rc = 0;
         end else rc++;
      end
      if (ia) begin
         n_in++;
         if (last != (wc == 15)) m_err = 1'b1;
         pf[rev4(wc)] = {im, re};
         if (wc == 15) begin
            q.push_back(pf);
            wc = 0;
         end else wc++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      chk("rst_out_data", bus.out_data_o, 32'd0);
      chk("rst_out_index", 32'(bus.out_index_o), 32'd0);
      chk("rst_out_last", 32'(bus.out_last_o), 32'd0);
      chk("rst_frame_err", 32'(bus.frame_err_o), 32'd0);
      q.delete();
      wc = 0;
      rc = 0;
      m_err = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.in_valid_i = 1'b0;
      bus.in_data_i = '0;
      bus.in_last_i = 1'b0;
      bus.out_ready_i = 1'b0;
      @(posedge clk);
      #1;
      do_reset();
      // single frame, Re=k Im=-k
      for (int k = 0; k < 16; k++) step(1'b1, 16'(k), 16'(-k), k == 15, 1'b1);
      for (int n = 0; n < 16; n++) begin
         step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
         chk("t1_re_table", 32'(seen_re), 32'(exp_re[n]));
      end
      // back-to-back frames
      n_out = 0;
      for (int f = 0; f < 4; f++)
         for (int k = 0; k < 16; k++) step(1'b1, 16'(16 * f + k), 16'($urandom), k == 15, 1'b1);
      for (int n = 0; n < 16; n++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
      chk("b2b_outputs", 32'(n_out), 32'd64);
      // backpressure: two full frames, then drain
      for (int k = 0; k < 34; k++) step(1'b1, 16'($urandom), 16'($urandom), (k % 16) == 15, 1'b0);
      for (int n = 0; n < 40; n++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
      chk("bp_drained", 32'(q.size()), 32'd0);
      // random valid/ready over 20 frames
      n_in = 0;
      n_out = 0;
      cyc = 0;
      while (n_in < 320 && cyc < 5000)
         step(1'($urandom % 2), 16'($urandom), 16'($urandom), wc == 15, 1'($urandom % 2));
      while (q.size() > 0 && cyc < 8000) step(1'b0, 16'd0, 16'd0, 1'b0, 1'($urandom % 2));
      chk("rand_in_count", 32'(n_in), 32'd320);
      chk("rand_out_count", 32'(n_out), 32'd320);
      // framing error on sample 9, then a clean frame keeps it sticky
      for (int k = 0; k < 16; k++) step(1'b1, 16'($urandom), 16'($urandom), k == 9, 1'b1);
      for (int k = 0; k < 16; k++) step(1'b1, 16'($urandom), 16'($urandom), k == 15, 1'b1);
      for (int n = 0; n < 16; n++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
      chk("err_sticky", 32'(bus.frame_err_o), 32'd1);
      // reset mid-write and mid-read
      for (int k = 0; k < 7; k++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      do_reset();
      for (int k = 0; k < 16; k++) step(1'b1, 16'($urandom), 16'($urandom), k == 15, 1'b0);
      for (int n = 0; n < 8; n++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
      do_reset();
      for (int k = 0; k < 16; k++) step(1'b1, 16'(100 + k), 16'(-k), k == 15, 1'b1);
      for (int n = 0; n < 16; n++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
      chk("final_empty_valid", 32'(bus.out_valid_o), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
